// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit beside the WISC ID stage: per-register in-flight table,
// flag-producer tracker, memory-busy freeze and a saturating stall-cycle counter.
module hazard_scoreboard #(
    parameter int unsigned REG_W          = 4,
    parameter int unsigned LOAD_LAT       = 1,
    parameter int unsigned BR_READY_AGE   = 2,
    parameter int unsigned FLAG_READY_AGE = 1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_valid,
    input  logic [REG_W-1:0] ID_SrcReg1,
    input  logic [REG_W-1:0] ID_SrcReg2,
    input  logic             ID_MemWrite,
    input  logic             ID_Branch,
    input  logic             ID_BR,
    input  logic             ID_HLT,
    input  logic             ID_RegWrite,
    input  logic             ID_MemRead,
    input  logic             ID_flag_en,
    input  logic [REG_W-1:0] ID_reg_rd,
    input  logic             update_PC,
    input  logic             mem_busy,
    output logic             PC_stall,
    output logic             IF_ID_stall,
    output logic             ID_flush,
    output logic             IF_flush,
    output logic             pipe_freeze,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned DEPTH   = 2 ** REG_W;
    localparam int unsigned MAX_LB  = (LOAD_LAT > BR_READY_AGE) ? LOAD_LAT : BR_READY_AGE;
    localparam int unsigned MAX_AGE = (MAX_LB > FLAG_READY_AGE) ? MAX_LB : FLAG_READY_AGE;

    localparam logic [1:0] MAX_AGE_V = 2'(MAX_AGE);
    localparam logic [1:0] LOAD_V    = 2'(LOAD_LAT);
    localparam logic [1:0] BR_V      = 2'(BR_READY_AGE);
    localparam logic [1:0] FLAG_V    = 2'(FLAG_READY_AGE);
    localparam logic [2:0] LOAD_V3   = 3'(LOAD_LAT);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] ld;
    logic [1:0]       age [DEPTH];
    logic             fvld;
    logic [1:0]       fage;
    logic [CNT_W-1:0] cnt;

    logic       rs_hit;
    logic       rt_hit;
    logic       rs_ld;
    logic       rt_ld;
    logic [1:0] rs_age;
    logic [1:0] rt_age;
    logic       lu_haz;
    logic       b_haz;
    logic       br_haz;
    logic       haz;
    logic       stall_c;
    logic       flush_c;
    logic       issue;

    // Table lookup for the two ID sources; register 0 never matches
    always_comb begin
        rs_hit = vld[ID_SrcReg1] & (ID_SrcReg1 != '0);
        rt_hit = vld[ID_SrcReg2] & (ID_SrcReg2 != '0);
        rs_ld  = ld[ID_SrcReg1];
        rt_ld  = ld[ID_SrcReg2];
        rs_age = age[ID_SrcReg1];
        rt_age = age[ID_SrcReg2];
    end

    // Store data of SW can take MEM-MEM forwarding, so it tolerates one cycle less
    always_comb begin
        lu_haz  = ID_valid & (
                      (rs_hit & rs_ld & (rs_age < LOAD_V)) |
                      (rt_hit & rt_ld & ~ID_MemWrite & (rt_age < LOAD_V)) |
                      (rt_hit & rt_ld & ID_MemWrite & (({1'b0, rt_age} + 3'd1) < LOAD_V3)));
        b_haz   = ID_valid & ID_Branch & fvld & (fage < FLAG_V);
        br_haz  = ID_valid & ID_Branch & ID_BR & rs_hit & (rs_age < BR_V);
        haz     = lu_haz | b_haz | br_haz;
        stall_c = mem_busy | ID_HLT | haz;
        flush_c = ~mem_busy & haz;
        issue   = ID_valid & ~flush_c & ~mem_busy;
    end

    assign pipe_freeze  = ~rst & mem_busy;
    assign IF_ID_stall  = ~rst & stall_c;
    assign PC_stall     = ~rst & stall_c;
    assign ID_flush     = ~rst & flush_c;
    assign IF_flush     = ~rst & update_PC & ~mem_busy;
    assign stall_cycles = rst ? '0 : cnt;

    // Register table: youngest issuing producer overwrites, others age out at MAX_AGE
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            ld  <= '0;
            for (int unsigned r = 0; r < DEPTH; r++) begin
                age[r] <= 2'd0;
            end
        end else if (!mem_busy) begin
            for (int unsigned r = 1; r < DEPTH; r++) begin
                if (issue && ID_RegWrite && (ID_reg_rd == REG_W'(r))) begin
                    vld[r] <= 1'b1;
                    ld[r]  <= ID_MemRead;
                    age[r] <= 2'd0;
                end else if (vld[r]) begin
                    if (age[r] == MAX_AGE_V) begin
                        vld[r] <= 1'b0;
                        age[r] <= 2'd0;
                    end else begin
                        age[r] <= age[r] + 2'd1;
                    end
                end
            end
        end
    end

    // Flag producer tracker
    always_ff @(posedge clk) begin
        if (rst) begin
            fvld <= 1'b0;
            fage <= 2'd0;
        end else if (!mem_busy) begin
            if (issue && ID_flag_en) begin
                fvld <= 1'b1;
                fage <= 2'd0;
            end else if (fvld) begin
                if (fage == FLAG_V) begin
                    fvld <= 1'b0;
                    fage <= 2'd0;
                end else begin
                    fage <= fage + 2'd1;
                end
            end
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (stall_c && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised scoreboard-based hazard unit for the pipelined WISC CPU, sitting beside the ID stage. It replaces fixed ID/EX and EX/MEM compare logic with a per-register in-flight table (valid, load, age), so load latency and branch-operand readiness are parameters. It also tracks the flag producer, freezes the pipeline on data-memory busy, and counts stall cycles. All stall and flush outputs are combinational from the table and the ID-stage inputs. State updates on `clk`.

## Interface
- `REG_W`, 4, register ID width; table depth is `2**REG_W`, and $0 is never tracked.
- `LOAD_LAT`, 1, range 1–3. Number of cycles after a load enters EX before its data is forwardable to an EX consumer.
- `BR_READY_AGE`, 2, range 1–3. Age at which a producer's result is readable in ID by BR (register-file bypass).
- `FLAG_READY_AGE`, 1, range 1–2. Age at which a flag producer's flags are usable by a B in ID.
- `CNT_W`, 16, stall counter width.
- `clk` in 1: single clock; all state on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ID_valid` in 1: ID holds a real instruction (not a bubble).
- `ID_SrcReg1`, `ID_SrcReg2` in REG_W each: Rs and Rt of the ID instruction.
- `ID_MemWrite` in 1: the ID instruction is SW.
- `ID_Branch`, `ID_BR`, `ID_HLT` in 1 each: ID instruction is B/BR, is BR, is HLT.
- `ID_RegWrite`, `ID_MemRead`, `ID_flag_en` in 1 each: the ID instruction writes rd, is LW, sets any flag.
- `ID_reg_rd` in REG_W: destination register of the ID instruction.
- `update_PC` in 1: branch redirect resolved in ID.
- `mem_busy` in 1: data memory is stalling the current access.
- `PC_stall`, `IF_ID_stall`, `ID_flush`, `IF_flush`, `pipe_freeze` out 1 each.
- `stall_cycles` out CNT_W: saturating count of cycles with `IF_ID_stall` high.

## Operation
- Table entry per register r≠0: `vld`, `ld`, and `age` (2 bits).
- `MAX_AGE = max(LOAD_LAT, BR_READY_AGE, FLAG_READY_AGE)`.
- Flag tracker: `fvld` and `fage`.
- **Issue** = `ID_valid & ~ID_flush & ~mem_busy`.
  - On issue with `ID_RegWrite` and `ID_reg_rd≠0`: the entry for rd is overwritten with vld=1, ld=`ID_MemRead`, age=0. The youngest producer always wins.
  - On issue with `ID_flag_en`: fvld=1, fage=0.
- **Aging** (each cycle `mem_busy`=0):
  - Every valid entry whose age < MAX_AGE increments.
  - An entry whose age = MAX_AGE clears vld.
  - Flag tracker follows the same rule against FLAG_READY_AGE.
  - Issue overwrite takes priority over aging for the same register.
- **Hazard terms** (all gated by `ID_valid`):
  - `lu_haz` (load-use):
    - Rs entry vld & ld & age < LOAD_LAT, or
    - Rt entry vld & ld & age < LOAD_LAT & ~ID_MemWrite, or
    - Rt entry vld & ld & ID_MemWrite & age < LOAD_LAT−1 (SW store data uses MEM-MEM forwarding).
  - `b_haz`: `ID_Branch & fvld & fage < FLAG_READY_AGE`.
  - `br_haz`: `ID_Branch & ID_BR & Rs entry vld & age < BR_READY_AGE`.
  - Source register 0 never matches.
- **Outputs:**
  - `pipe_freeze = mem_busy`.
  - `IF_ID_stall = PC_stall = mem_busy | ID_HLT | lu_haz | b_haz | br_haz`.
  - `ID_flush = ~mem_busy & (lu_haz | b_haz | br_haz)`. A freeze holds ID/EX and never flushes it.
  - `IF_flush = update_PC & ~mem_busy`.
- `stall_cycles` increments when `IF_ID_stall`=1 and saturates at all-ones.

## Timing
- Hazard outputs are zero-latency combinational from inputs and the current table; the table changes only on the rising edge.
- Reset, with `rst` high at an edge:
  - All vld=0, fvld=0, ages=0, `stall_cycles`=0.
  - While `rst` is high, every output is forced to 0.
- Reset mid-operation discards all in-flight entries; the first post-reset cycle sees no hazards.
- With defaults, the behaviour equals the legacy hazard unit:
  - LW→use stalls 1 cycle.
  - BR after an ALU write stalls 2 cycles (ages 0 and 1).
  - B after a flag setter stalls 1 cycle.
- Load-use stall length is LOAD_LAT cycles when the load issues immediately before the consumer.
- During `mem_busy` no aging and no issue occur; a hazard resumes with the same remaining count after `mem_busy` falls.
- Simultaneous events:
  - `update_PC` & hazard: both IF_flush and ID_flush assert.
  - HLT & hazard: stall asserts once (OR).
  - A stalled instruction never issues, since ID_flush blocks issue.

## Test plan
- Load-use, defaults: LW R3, then ADD R4,R3,R5 → IF_ID_stall=ID_flush=1 for exactly 1 cycle, then issue.
- Store forwarding: LW R3, then SW R3,0(R2) with Rt=R3 → no stall. With LOAD_LAT=2 the same sequence → 1-cycle stall; LW→ADD stalls 2.
- BR readiness: ADD R7, then BR R7 → stall 2 cycles. Retire timing: ADD R7, NOP, then BR → stall 1 cycle. ADD R0 then BR R0 → no stall.
- Flags: SUB (flag_en), then B → 1-cycle stall. Freeze: the same pair with mem_busy=1 for 3 cycles in the hazard window → ID_flush=0 and pipe_freeze=1 during the busy cycles; exactly 1 hazard cycle remains afterwards.
- Youngest-wins: LW R2, then ADD R2 (overwrite), then ADD R6,R2,R1 → no load-use stall.
- Reset and counter:
  - Assert rst with 2 live entries → all outputs 0 while rst is high; after release, BR on those registers sees no stall and stall_cycles=0.
  - Drive 70000 stall cycles → stall_cycles=0xFFFF.
